// File: rtl/disp_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan controller.
// Contents:
//   scan_state_t : per-slot phase (BLANK dead-time, then SHOW)
//   NUM_DIGITS   : number of multiplexed digits
//   SEG_OFF      : all segments off (active-low)
//   AN_OFF       : all anodes off (active-low)
//   lz_mask()    : eligibility mask that suppresses leading-zero digits
package disp_pkg;

  typedef enum logic {BLANK, SHOW} scan_state_t;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Bit k set when digit k is at or below the most-significant nonzero nibble.
  // Digit 0 is always eligible so a zero value still shows a single '0'.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] value);
    logic [NUM_DIGITS-1:0] mask;
    logic                  seen;
    mask = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (value[4*k +: 4] != 4'h0) seen = 1'b1;
      mask[k] = seen;
    end
    mask[0] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to 7-segment decoder, active-low outputs.
// Ports:
//   i_nibble : 4-bit hex digit 0..F
//   o_seg    : segments, active-low, o_seg[0]=a ... o_seg[6]=g
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Patterns written active-high (gfedcba) and inverted once at the output.
  logic [6:0] w_on;

  always_comb begin
    w_on = 7'h00;
    unique case (i_nibble)
      4'h0: w_on = 7'h3F;
      4'h1: w_on = 7'h06;
      4'h2: w_on = 7'h5B;
      4'h3: w_on = 7'h4F;
      4'h4: w_on = 7'h66;
      4'h5: w_on = 7'h6D;
      4'h6: w_on = 7'h7D;
      4'h7: w_on = 7'h07;
      4'h8: w_on = 7'h7F;
      4'h9: w_on = 7'h6F;
      4'hA: w_on = 7'h77;
      4'hB: w_on = 7'h7C;
      4'hC: w_on = 7'h39;
      4'hD: w_on = 7'h5E;
      4'hE: w_on = 7'h79;
      4'hF: w_on = 7'h71;
    endcase
  end

  assign o_seg = ~w_on;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display.
// Accepts a 32-bit hex value over valid/ready, double-buffers it (pending -> shadow at
// frame boundaries) and time-multiplexes the anodes with a dead-time blank per slot.
// Optional feature: define LEADING_ZERO_BLANK_EN to turn off digits above the
// most-significant nonzero nibble.
// Ports:
//   CLK100MHZ   : system clock
//   reset_n     : asynchronous active-low reset
//   data_in     : hex value, nibble k on digit k (digit 0 rightmost)
//   data_valid  : producer has data_in valid
//   data_ready  : controller can accept data_in this cycle
//   digit_en    : live per-digit enable
//   frame_start : one-cycle pulse at start of the digit 0 slot
//   AN          : anodes, active-low
//   D7S         : segments, active-low, D7S[0]=a ... D7S[6]=g
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [7:0]  digit_en,
  output logic        frame_start,
  output logic [7:0]  AN,
  output logic [6:0] D7S
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_idx;
  scan_state_t     r_state;
  logic [31:0]     r_pend;
  logic            r_pend_full;
  logic [31:0]     r_shadow;
  logic [7:0]      r_an;
  logic [6:0]      r_d7s;
  logic            r_frame_start;

  logic            w_slot_end;
  logic            w_frame_end;
  logic [CntW-1:0] w_cnt_next;
  logic [3:0]      w_nibble;
  logic [6:0]      w_seg;
  logic [7:0]      w_elig;
  logic [7:0]      w_an_show;

  assign w_slot_end  = (r_cnt == CntW'(TICK_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == 3'd7);
  assign w_cnt_next  = w_slot_end ? '0 : r_cnt + 1'b1;
  assign w_nibble    = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_an_show   = ~(8'd1 << r_idx);

`ifdef LEADING_ZERO_BLANK_EN
  assign w_elig = digit_en & lz_mask(r_shadow);
`else
  assign w_elig = digit_en;
`endif

  seg7_decode u_seg7_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_state       <= BLANK;
      r_pend        <= '0;
      r_pend_full   <= 1'b0;
      r_shadow      <= '0;
      r_an          <= AN_OFF;
      r_d7s         <= SEG_OFF;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_slot_end) r_idx <= r_idx + 3'd1;
      // State tracks the counter value being loaded, so r_state always matches r_cnt.
      r_state       <= (32'(w_cnt_next) < BLANK_CYCLES) ? BLANK : SHOW;
      r_frame_start <= w_frame_end;

      // Commit and accept are exclusive: ready is low whenever pending is full.
      if (w_frame_end && r_pend_full) begin
        r_shadow    <= r_pend;
        r_pend      <= '0;
        r_pend_full <= 1'b0;
      end else if (data_valid && !r_pend_full) begin
        r_pend      <= data_in;
        r_pend_full <= 1'b1;
      end

      if (r_state == SHOW) begin
        r_an  <= w_elig[r_idx] ? w_an_show : AN_OFF;
        r_d7s <= w_seg;
      end else begin
        r_an  <= AN_OFF;
        r_d7s <= SEG_OFF;
      end
    end
  end

  assign data_ready  = ~r_pend_full;
  assign frame_start = r_frame_start;
  assign AN          = r_an;
  assign D7S         = r_d7s;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with TICK_DIV=10, BLANK_CYCLES=2.
module tb_disp_scan_ctrl;

  localparam int TICK  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * TICK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic        dv;
  logic        dr;
  logic [7:0]  den;
  logic        fs;
  logic [7:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  disp_scan_ctrl #(
    .TICK_DIV     (TICK),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK100MHZ   (clk),
    .reset_n     (rst_n),
    .data_in     (din),
    .data_valid  (dv),
    .data_ready  (dr),
    .digit_en    (den),
    .frame_start (fs),
    .AN          (an),
    .D7S         (seg)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  shown_plain;  // digits lit without leading-zero blanking
    logic [7:0]  shown_lz;     // digits lit with leading-zero blanking
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic push_frame(input logic [31:0] data, input logic [7:0] shown);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      e.an  = shown[d] ? ~(8'd1 << d) : 8'hFF;
      e.seg = model_seg(data[4*d +: 4]);
      exp_q.push_back(e);
    end
  endtask

  // Returns the number of negedges waited until frame_start was seen.
  task automatic wait_fs(output int n);
    for (n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (fs) return;
    end
    check("frame_start timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [31:0] data);
    for (int n = 0; n < 200 && !dr; n++) @(negedge clk);
    check("ready before load", dr, 1'b1);
    din = data;
    dv  = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    check("ready after accept", dr, 1'b0);
  endtask

  // Called at the negedge where frame_start is high; AN at offset t reflects slot t-1.
  task automatic observe_frame(input bit drop_valid);
    exp_t e;
    e = '{an: 8'hFF, seg: 7'h7F};
    for (int t = 1; t <= FRAME; t++) begin
      int c;
      int d;
      @(negedge clk);
      if (t == 1 && drop_valid) begin
        check("ready after boundary accept", dr, 1'b0);
        dv = 1'b0;
      end
      c = (t - 1) % TICK;
      d = (t - 1) / TICK;
      if (c == BLANK) begin
        if (exp_q.size() == 0) check("scoreboard empty", 32'd0, 32'd1);
        else e = exp_q.pop_front();
      end
      if (c < BLANK) begin
        check($sformatf("blank AN digit %0d cyc %0d", d, c), an, 8'hFF);
        check($sformatf("blank D7S digit %0d cyc %0d", d, c), seg, 7'h7F);
      end else begin
        check($sformatf("show AN digit %0d cyc %0d", d, c), an, e.an);
        check($sformatf("show D7S digit %0d cyc %0d", d, c), seg, e.seg);
      end
      if (t == FRAME / 2) check("frame_start mid-frame", fs, 1'b0);
      if (t == FRAME) check("frame_start period", fs, 1'b1);
    end
  endtask

  function automatic logic [7:0] pick_shown(input vec_t v);
`ifdef LEADING_ZERO_BLANK_EN
    return v.shown_lz;
`else
    return v.shown_plain;
`endif
  endfunction

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{data: 32'h1234_5678, en: 8'hFF, shown_plain: 8'hFF, shown_lz: 8'hFF};
    vecs[1] = '{data: 32'hDEAD_BEEF, en: 8'hFF, shown_plain: 8'hFF, shown_lz: 8'hFF};
    vecs[2] = '{data: 32'h0000_0000, en: 8'hFF, shown_plain: 8'hFF, shown_lz: 8'h01};
    vecs[3] = '{data: 32'h0000_00A5, en: 8'hFF, shown_plain: 8'hFF, shown_lz: 8'h03};
    vecs[4] = '{data: 32'h1234_5678, en: 8'h0F, shown_plain: 8'h0F, shown_lz: 8'h0F};
    vecs[5] = '{data: 32'h00F0_0000, en: 8'hAA, shown_plain: 8'hAA, shown_lz: 8'h2A};

    rst_n = 1'b0;
    din   = '0;
    dv    = 1'b0;
    den   = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset AN", an, 8'hFF);
    check("reset D7S", seg, 7'h7F);
    check("reset ready", dr, 1'b1);
    check("reset frame_start", fs, 1'b0);
    rst_n = 1'b1;

    // Table-driven frames: load, wait for the commit boundary, check a whole frame.
    for (int i = 0; i < 6; i++) begin
      den = vecs[i].en;
      load(vecs[i].data);
      wait_fs(n);
      check($sformatf("ready after commit vec %0d", i), dr, 1'b1);
      push_frame(vecs[i].data, pick_shown(vecs[i]));
      observe_frame(1'b0);
    end

    // Back-pressure: second word held while ready=0, accepted on the commit cycle.
    den = 8'hFF;
    din = 32'h1234_5678;
    dv  = 1'b1;
    @(negedge clk);
    check("bp first accepted", dr, 1'b0);
    din = 32'hDEAD_BEEF;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (fs) break;
      if (n % 20 == 0) check($sformatf("bp ready held low n=%0d", n), dr, 1'b0);
    end
    check("bp ready at frame_start", dr, 1'b1);
    push_frame(32'h1234_5678, 8'hFF);
    observe_frame(1'b1);
    check("bp ready after second commit", dr, 1'b1);
    push_frame(32'hDEAD_BEEF, 8'hFF);
    observe_frame(1'b0);

    // Reset mid-frame at digit 5 with a word pending.
    load(32'hCAFE_F00D);
    repeat (54) @(negedge clk);
    check("pre-reset AN digit 5", an, 8'hDF);
    rst_n = 1'b0;
    #1;
    check("mid reset AN", an, 8'hFF);
    check("mid reset D7S", seg, 7'h7F);
    check("mid reset ready", dr, 1'b1);
    check("mid reset frame_start", fs, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n);
    check("first frame length after reset", n, FRAME);
`ifdef LEADING_ZERO_BLANK_EN
    push_frame(32'h0, 8'h01);
`else
    push_frame(32'h0, 8'hFF);
`endif
    observe_frame(1'b0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
